// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, one stop bit.
// All outputs are registered and reflect the FSM state that is being entered.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [2:0]       idx;
  logic [2:0]       idx_next;
  logic [7:0]       data;
  logic [7:0]       data_next;
  logic             bit_end;
  logic             parity;
  logic             tx_d;
  logic             ready_d;
  logic             busy_d;
  logic             done_d;

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign parity  = (^data) ^ (PARITY_ODD != 0);

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      data    <= '0;
      o_tx    <= 1'b1;
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      idx     <= idx_next;
      data    <= data_next;
      o_tx    <= tx_d;
      o_ready <= ready_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

  // Next-state logic: bit-period counter, data bit index and frame sequencing.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    data_next  = data;
    if (state != IDLE) begin
      cnt_next = bit_end ? '0 : cnt + CNT_W'(1);
    end
    case (state)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (i_valid && o_ready) begin
          data_next  = i_data;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          idx_next = idx + 3'd1;
          if (idx == 3'd7) state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic evaluated on the upcoming state so the registers match it.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = (state_next == IDLE);
    busy_d  = (state_next != IDLE);
    done_d  = (state == STOP) && (state_next == IDLE);
    case (state_next)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data[idx_next];
      PARITY:  tx_d = parity;
      default: tx_d = 1'b1;
    endcase
  end

endmodule
